seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameters: none; the datapath is fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 opdata1_i  in  32  dividend; sampled with start.
REQ-006 opdata2_i  in  32  divisor; sampled with start.
REQ-007 start_i  in  1  request, level-held by the requester until ready_o is seen high.
REQ-008 annul_i  in  1  abort the operation in progress.
REQ-009 result_o  out  64  [63:32] remainder (HI), [31:0] quotient (LO).
REQ-010 ready_o  out  1  result_o valid.

Function
REQ-011 The block SHALL be an FSM with four states: FREE, BY_ZERO, ON, END.
REQ-012 In FREE with start_i=1, annul_i=0 and opdata2_i=0, the FSM SHALL go to BY_ZERO.
REQ-013 In FREE with start_i=1, annul_i=0 and opdata2_i≠0, the FSM SHALL latch operands and sign mode, clear the iteration counter, and go to ON.
REQ-014 In FREE, if start_i=0 or annul_i=1, the FSM SHALL stay in FREE.
REQ-015 In signed mode, a negative operand SHALL be replaced by its two's-complement magnitude at latch time; unsigned mode latches operands unchanged.
REQ-016 In ON, the FSM SHALL perform one restoring shift-subtract step per cycle on a 65-bit working register (partial remainder : dividend).
REQ-017 After exactly 32 steps, the FSM SHALL go to END.
REQ-018 annul_i=1 in ON SHALL return the FSM to FREE on the next edge; ready_o SHALL never assert for that operation.
REQ-019 Signed quotient SHALL be negated when the dividend sign XOR the divisor sign is 1.
REQ-020 Signed remainder SHALL take the sign of the dividend.
REQ-021 Signed -2^31 / -1 SHALL yield quotient 0x80000000 (wrap) and remainder 0.
REQ-022 BY_ZERO SHALL go to END on the next edge with result 64'h0.
REQ-023 In END, ready_o SHALL be 1 and result_o SHALL hold the final value.
REQ-024 In END, start_i=0 SHALL go to FREE on the next edge, with ready_o=0 and result_o=0.
REQ-025 In END, start_i=1 SHALL keep the FSM in END with the result held.
REQ-026 Outside END, ready_o SHALL be 0 and result_o SHALL be 64'h0.
REQ-027 Latency from the start-accept edge: ready_o SHALL rise 33 cycles later for a nonzero divisor and 2 cycles later for a zero divisor.
REQ-028 Operand changes on opdata1_i, opdata2_i and signed_div_i after acceptance SHALL NOT affect the result.
REQ-029 ready_o and result_o SHALL be registered outputs.

Reset
REQ-030 rst=1 at a clock edge SHALL force FREE, counter 0, working register 0, ready_o=0 and result_o=0.
REQ-031 Reset SHALL take priority over start_i and annul_i, including mid-operation in ON or END.
REQ-032 After rst deasserts, a held start_i SHALL be accepted as a fresh request on the first FREE cycle.

Verification
REQ-033 Unsigned 7/2: start_i=1 with 7 and 2, held; ready_o rises 33 cycles after accept with result_o=0x00000001_00000003.
REQ-034 Signed -7/2 (0xFFFFFFF9, 2): result_o=0xFFFFFFFF_FFFFFFFD; unsigned 0xFFFFFFFF/1 gives 0x00000000_FFFFFFFF.
REQ-035 Divide by zero (opdata2_i=0): ready_o rises 2 cycles after accept with result_o=0.
REQ-036 Abort: annul_i pulsed at step 10 of ON; FSM returns to FREE and ready_o stays 0; a following 100/7 yields 0x00000002_0000000E.
REQ-037 Handshake: start_i held high 3 cycles in END keeps ready_o=1 and result stable; dropping start_i gives ready_o=0 and result_o=0 on the next cycle.
REQ-038 Reset at step 20 of ON: outputs are 0 next cycle; -2^31/-1 then yields 0x00000000_80000000.

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/response bundle between a requester and the sequential 32-bit divider.
// The requester holds start_i until it sees ready_o, then drops it to release the result.
interface seq_divider_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, 32/32 -> {remainder, quotient}, signed or unsigned.
// One quotient bit per cycle; result held while start_i stays high after completion.
module seq_divider (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor;
  logic        neg_quo;
  logic        neg_rem;
  logic [63:0] result;
  logic        ready;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [65:0] shifted;
  logic [33:0] trial;
  logic [64:0] work_step;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
  logic        accept;

  assign accept = bus.start_i && !bus.annul_i;

  // Signed operands are reduced to magnitudes; signs are re-applied at the end.
  assign mag_a = (bus.signed_div_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
  assign mag_b = (bus.signed_div_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;

  // Partial remainder never exceeds the divisor, so a 34-bit trial subtract shows borrow in bit 33.
  assign shifted   = {work, 1'b0};
  assign trial     = shifted[65:32] - {2'b00, divisor};
  assign work_step = trial[33] ? shifted[64:0] : {trial[32:0], work[30:0], 1'b1};

  assign quo_final = neg_quo ? (32'd0 - work[31:0])  : work[31:0];
  assign rem_final = neg_rem ? (32'd0 - work[63:32]) : work[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FREE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FREE: begin
        if (accept) begin
          state_next = (bus.opdata2_i == 32'd0) ? S_BY_ZERO : S_ON;
        end
      end
      S_BY_ZERO: state_next = S_END;
      S_ON: begin
        if (bus.annul_i) begin
          state_next = S_FREE;
        end else if (cnt == 6'd31) begin
          state_next = S_END;
        end
      end
      S_END: begin
        if (!bus.start_i) begin
          state_next = S_FREE;
        end
      end
      default: state_next = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 6'd0;
      work    <= 65'd0;
      divisor <= 32'd0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      ready   <= 1'b0;
      result  <= 64'd0;
    end else begin
      ready  <= 1'b0;
      result <= 64'd0;
      case (state)
        S_FREE: begin
          if (accept) begin
            cnt <= 6'd0;
            if (bus.opdata2_i == 32'd0) begin
              work    <= 65'd0;
              divisor <= 32'd0;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
            end else begin
              work    <= {33'd0, mag_a};
              divisor <= mag_b;
              neg_quo <= bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
              neg_rem <= bus.signed_div_i && bus.opdata1_i[31];
            end
          end
        end
        S_ON: begin
          if (!bus.annul_i) begin
            work <= work_step;
            cnt  <= cnt + 6'd1;
          end
        end
        S_END: begin
          if (bus.start_i) begin
            ready  <= 1'b1;
            result <= {rem_final, quo_final};
          end
        end
        default: begin
          ready  <= 1'b0;
          result <= 64'd0;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready;
  assign bus.result_o = result;

endmodule

// File: tb/tb_seq_divider.sv
// Directed checks of seq_divider: vector table for results/latency, plus abort,
// mid-operation reset and result-hold handshake sequences.
module tb_seq_divider;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sdiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called #1 after the accept edge: measures latency, checks result, hold and release.
  task automatic finish_op(input string name, input int lat, input logic [63:0] exp, input int hold);
    int n;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_result"}, bus.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_ready"}, {63'd0, bus.ready_o}, 64'd1);
      chk({name, "_hold_result"}, bus.result_o, exp);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_release_ready"}, {63'd0, bus.ready_o}, 64'd0);
    chk({name, "_release_result"}, bus.result_o, 64'd0);
  endtask

  task automatic run_div(input vec_t v);
    @(negedge clk);
    bus.signed_div_i = v.sdiv;
    bus.opdata1_i    = v.a;
    bus.opdata2_i    = v.b;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    // Operands change after acceptance and must be ignored.
    bus.signed_div_i = ~v.sdiv;
    bus.opdata1_i    = ~v.a;
    bus.opdata2_i    = v.b ^ 32'h5A5A_0001;
    finish_op(v.name, v.lat, v.exp, v.hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{"u_7_2",        1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33, 3};
    vecs[1] = '{"s_m7_2",       1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 0};
    vecs[2] = '{"u_ffff_1",     1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, 0};
    vecs[3] = '{"u_7_0",        1'b0, 32'd7,        32'd0,        64'h00000000_00000000, 2,  1};
    vecs[4] = '{"s_7_m2",       1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0};
    vecs[5] = '{"s_m7_m2",      1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, 0};
    vecs[6] = '{"u_fff9_2",     1'b0, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, 33, 0};
    vecs[7] = '{"s_min_m1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0};
    vecs[8] = '{"u_5_9",        1'b0, 32'd5,        32'd9,        64'h00000005_00000000, 33, 0};

    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i]);
    end

    // Abort after 10 steps; ready must never appear for the aborted operation.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) seen = 1'b1;
    end
    chk("abort_no_ready", {63'd0, seen}, 64'd0);
    run_div('{"u_100_7_after_abort", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0});

    // Reset 20 steps into an operation while start stays held with a new request.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst              = 1'b1;
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'h80000000;
    bus.opdata2_i    = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    finish_op("s_min_m1_after_rst", 33, 64'h00000000_80000000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
